// File: rtl/rv32i_mem_arbiter_if.sv
// Bus bundle between the rv32i data port, the host (APF bridge) port,
// the shared data RAM and the arbiter.
// The slave modport is the arbiter's view. The master modport is the view of
// the requesters and the RAM.
interface rv32i_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // core data port
  logic                  core_req;
  logic                  core_we;
  logic [ADDR_W-1:0]     core_addr;
  logic [DATA_W-1:0]     core_wdata;
  logic [DATA_W/8-1:0]   core_be;
  logic                  core_gnt;
  logic                  core_rvalid;
  logic [DATA_W-1:0]     core_rdata;
  // host port
  logic                  host_req;
  logic                  host_we;
  logic [ADDR_W-1:0]     host_addr;
  logic [DATA_W-1:0]     host_wdata;
  logic [DATA_W/8-1:0]   host_be;
  logic                  host_gnt;
  logic                  host_rvalid;
  logic [DATA_W-1:0]     host_rdata;
  logic                  host_lock;
  logic                  host_lock_ack;
  // RAM side
  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W/8-1:0]   mem_be;
  logic [DATA_W-1:0]     mem_rdata;

  modport slave (
    input  core_req, core_we, core_addr, core_wdata, core_be,
    input  host_req, host_we, host_addr, host_wdata, host_be, host_lock,
    input  mem_rdata,
    output core_gnt, core_rvalid, core_rdata,
    output host_gnt, host_rvalid, host_rdata, host_lock_ack,
    output mem_en, mem_we, mem_addr, mem_wdata, mem_be
  );

  modport master (
    output core_req, core_we, core_addr, core_wdata, core_be,
    output host_req, host_we, host_addr, host_wdata, host_be, host_lock,
    output mem_rdata,
    input  core_gnt, core_rvalid, core_rdata,
    input  host_gnt, host_rvalid, host_rdata, host_lock_ack,
    input  mem_en, mem_we, mem_addr, mem_wdata, mem_be
  );
endinterface

// File: rtl/rv32i_mem_arbiter.sv
// rv32i_mem_arbiter: shares the single-port data RAM between the core data
// port and the host port.
//  - Grants one port per cycle and muxes its command onto the RAM.
//  - Reads are tagged by owner in a RD_LATENCY-deep pipe, which steers the
//    returning data back to the right port.
//  - A lock FSM gives the host exclusive access.
// Optional feature macro: RV32I_MEM_ARB_HOST_PRIORITY_EN.
//  - Defined: in the shared state the host wins every tie.
//  - Undefined: ties alternate round-robin.
module rv32i_mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset,
  rv32i_mem_arbiter_if.slave  bus
);
  localparam int BE_W = DATA_W / 8;
  localparam logic OWNER_CORE = 1'b0;
  localparam logic OWNER_HOST = 1'b1;

  typedef enum logic [1:0] {
    SHARED    = 2'd0,
    LOCK_PEND = 2'd1,
    LOCKED    = 2'd2,
    UNLOCK    = 2'd3
  } state_t;

  state_t                state_r;
  state_t                state_next_s;
  logic                  last_owner_r;
  logic [RD_LATENCY-1:0] pipe_valid_r;
  logic [RD_LATENCY-1:0] pipe_owner_r;
  logic [DATA_W-1:0]     core_rdata_r;
  logic [DATA_W-1:0]     host_rdata_r;

  logic                  core_pick_s;
  logic                  host_pick_s;
  logic                  core_grant_s;
  logic                  host_grant_s;
  logic                  rd_accept_s;
  logic                  core_in_flight_s;
  logic                  head_core_s;
  logic                  head_host_s;
  logic                  mem_en_s;
  logic                  mem_we_s;
  logic [ADDR_W-1:0]     mem_addr_s;
  logic [DATA_W-1:0]     mem_wdata_s;
  logic [BE_W-1:0]       mem_be_s;

  // Any core read still travelling down the pipe, including the one at its
  // head, keeps LOCK_PEND from completing.
  assign core_in_flight_s = |(pipe_valid_r & ~pipe_owner_r);

  // Grants are forced low while reset is held, so no command leaks to the RAM.
  assign core_grant_s = core_pick_s & ~reset;
  assign host_grant_s = host_pick_s & ~reset;
  assign rd_accept_s  = (core_grant_s & ~bus.core_we) | (host_grant_s & ~bus.host_we);

  assign head_core_s  = pipe_valid_r[RD_LATENCY-1] & (pipe_owner_r[RD_LATENCY-1] == OWNER_CORE);
  assign head_host_s  = pipe_valid_r[RD_LATENCY-1] & (pipe_owner_r[RD_LATENCY-1] == OWNER_HOST);

  // Grant selection and lock FSM next state
  always_comb begin
    state_next_s = state_r;
    core_pick_s  = 1'b0;
    host_pick_s  = 1'b0;
    case (state_r)
      SHARED: begin
`ifdef RV32I_MEM_ARB_HOST_PRIORITY_EN
        if (bus.host_req) begin
          host_pick_s = 1'b1;
        end else if (bus.core_req) begin
          core_pick_s = 1'b1;
        end else begin
          host_pick_s = 1'b0;
        end
`else
        if (bus.core_req && bus.host_req) begin
          core_pick_s = (last_owner_r == OWNER_HOST);
          host_pick_s = (last_owner_r == OWNER_CORE);
        end else if (bus.core_req) begin
          core_pick_s = 1'b1;
        end else if (bus.host_req) begin
          host_pick_s = 1'b1;
        end else begin
          core_pick_s = 1'b0;
        end
`endif
        if (bus.host_lock) begin
          state_next_s = LOCK_PEND;
        end else begin
          state_next_s = SHARED;
        end
      end
      LOCK_PEND: begin
        host_pick_s = bus.host_req;
        if (!bus.host_lock) begin
          state_next_s = SHARED;
        end else if (!core_in_flight_s) begin
          state_next_s = LOCKED;
        end else begin
          state_next_s = LOCK_PEND;
        end
      end
      LOCKED: begin
        host_pick_s = bus.host_req;
        if (!bus.host_lock) begin
          state_next_s = UNLOCK;
        end else begin
          state_next_s = LOCKED;
        end
      end
      UNLOCK: begin
        state_next_s = SHARED;
      end
      default: begin
        state_next_s = SHARED;
      end
    endcase
  end

  // Steer the granted port's command onto the RAM; idle bus is all zeros
  always_comb begin
    mem_en_s    = 1'b0;
    mem_we_s    = 1'b0;
    mem_addr_s  = {ADDR_W{1'b0}};
    mem_wdata_s = {DATA_W{1'b0}};
    mem_be_s    = {BE_W{1'b0}};
    if (core_grant_s) begin
      mem_en_s    = 1'b1;
      mem_we_s    = bus.core_we;
      mem_addr_s  = bus.core_addr;
      mem_wdata_s = bus.core_wdata;
      mem_be_s    = bus.core_be;
    end else if (host_grant_s) begin
      mem_en_s    = 1'b1;
      mem_we_s    = bus.host_we;
      mem_addr_s  = bus.host_addr;
      mem_wdata_s = bus.host_wdata;
      mem_be_s    = bus.host_be;
    end else begin
      mem_en_s    = 1'b0;
    end
  end

  // Lock state and round-robin pointer; the host counts as last owner out
  // of reset so the core wins the first tie
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= SHARED;
      last_owner_r <= OWNER_HOST;
    end else begin
      state_r <= state_next_s;
      if (core_grant_s) begin
        last_owner_r <= OWNER_CORE;
      end else if (host_grant_s) begin
        last_owner_r <= OWNER_HOST;
      end else begin
        last_owner_r <= last_owner_r;
      end
    end
  end

  // Read tag pipe: one {valid, owner} stage per cycle of RAM latency
  generate
    if (RD_LATENCY > 1) begin : g_pipe_deep
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          pipe_valid_r <= {RD_LATENCY{1'b0}};
          pipe_owner_r <= {RD_LATENCY{1'b0}};
        end else begin
          pipe_valid_r <= {pipe_valid_r[RD_LATENCY-2:0], rd_accept_s};
          pipe_owner_r <= {pipe_owner_r[RD_LATENCY-2:0], host_grant_s};
        end
      end
    end else begin : g_pipe_single
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          pipe_valid_r <= 1'b0;
          pipe_owner_r <= 1'b0;
        end else begin
          pipe_valid_r <= rd_accept_s;
          pipe_owner_r <= host_grant_s;
        end
      end
    end
  endgenerate

  // Remember the last delivered word per port so rdata holds between reads
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      core_rdata_r <= {DATA_W{1'b0}};
      host_rdata_r <= {DATA_W{1'b0}};
    end else begin
      if (head_core_s) begin
        core_rdata_r <= bus.mem_rdata;
      end else begin
        core_rdata_r <= core_rdata_r;
      end
      if (head_host_s) begin
        host_rdata_r <= bus.mem_rdata;
      end else begin
        host_rdata_r <= host_rdata_r;
      end
    end
  end

  assign bus.core_gnt      = core_grant_s;
  assign bus.host_gnt      = host_grant_s;
  assign bus.core_rvalid   = head_core_s;
  assign bus.host_rvalid   = head_host_s;
  assign bus.core_rdata    = head_core_s ? bus.mem_rdata : core_rdata_r;
  assign bus.host_rdata    = head_host_s ? bus.mem_rdata : host_rdata_r;
  assign bus.host_lock_ack = (state_r == LOCKED);
  assign bus.mem_en        = mem_en_s;
  assign bus.mem_we        = mem_we_s;
  assign bus.mem_addr      = mem_addr_s;
  assign bus.mem_wdata     = mem_wdata_s;
  assign bus.mem_be        = mem_be_s;
endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Self-checking bench for rv32i_mem_arbiter.
// A behavioural RAM answers the arbiter with RD_LATENCY cycles of delay.
// A scoreboard queues the expected {owner, data, grant cycle} of every granted
// read and checks them off against rvalid.
module tb_rv32i_mem_arbiter;
  localparam int LAT = 2;
  localparam int AW  = 32;
  localparam int DW  = 32;
`ifdef RV32I_MEM_ARB_HOST_PRIORITY_EN
  localparam bit HP = 1'b1;
`else
  localparam bit HP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rv32i_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

  rv32i_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [31:0] init_word(input logic [7:0] i);
    return 32'h3C00_0000 ^ ({24'h0, i} * 32'h0001_0101);
  endfunction

  function automatic logic [31:0] merge_be(input logic [31:0] old, input logic [31:0] nw,
                                           input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // Behavioural single-port RAM with LAT cycles of read latency
  bit   [31:0] ram    [256];
  bit          ram_wr [256];
  logic [31:0] rd_pipe[LAT];

  function automatic logic [31:0] ram_word(input logic [7:0] i);
    return ram_wr[i] ? ram[i] : init_word(i);
  endfunction

  always @(posedge clk) begin
    if (bus.mem_en && bus.mem_we) begin
      ram[bus.mem_addr[9:2]]    <= merge_be(ram_word(bus.mem_addr[9:2]), bus.mem_wdata, bus.mem_be);
      ram_wr[bus.mem_addr[9:2]] <= 1'b1;
    end
    rd_pipe[0] <= (bus.mem_en && !bus.mem_we) ? ram_word(bus.mem_addr[9:2]) : 32'h0;
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bus.mem_rdata = rd_pipe[LAT-1];

  // Reference memory, updated only from the bench's own view of granted writes
  logic [31:0] ref_mem [256];
  bit          ref_wr  [256];
  function automatic logic [31:0] ref_word(input logic [7:0] i);
    return ref_wr[i] ? ref_mem[i] : init_word(i);
  endfunction

  typedef struct {
    logic        owner;
    logic [31:0] data;
    int          cyc;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    logic        c_req;
    logic        h_req;
    logic [31:0] c_addr;
    logic [31:0] h_addr;
    logic        exp_cg;
    logic        exp_hg;
  } vec_t;
  vec_t vecs[8];

  int errors = 0;
  int checks = 0;
  int cycle  = 0;
  int last_core_rv = -1;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic pop_check(input logic owner, input logic [31:0] data);
    sb_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL rvalid_unexpected: got rvalid owner %b expected none (cycle %0d)", owner, cycle);
    end else begin
      e = sb.pop_front();
      chk1("rd_owner", owner, e.owner);
      chk32("rd_data", data, e.data);
      chk32("rd_latency", 32'(cycle - e.cyc), 32'(LAT));
    end
  endtask

  // Per-cycle invariants, rvalid scoreboard and expectation capture
  task automatic monitor();
    chk1("gnt_exclusive", bus.core_gnt & bus.host_gnt, 1'b0);
    chk1("core_gnt_needs_req", bus.core_gnt & ~bus.core_req, 1'b0);
    chk1("host_gnt_needs_req", bus.host_gnt & ~bus.host_req, 1'b0);
    chk1("mem_en", bus.mem_en, bus.core_gnt | bus.host_gnt);
    if (bus.core_rvalid) begin
      last_core_rv = cycle;
      pop_check(1'b0, bus.core_rdata);
    end
    if (bus.host_rvalid) pop_check(1'b1, bus.host_rdata);
    if (bus.core_gnt) begin
      if (bus.core_we) begin
        ref_mem[bus.core_addr[9:2]] = merge_be(ref_word(bus.core_addr[9:2]), bus.core_wdata, bus.core_be);
        ref_wr[bus.core_addr[9:2]]  = 1'b1;
      end else begin
        sb.push_back('{owner: 1'b0, data: ref_word(bus.core_addr[9:2]), cyc: cycle});
      end
    end
    if (bus.host_gnt) begin
      if (bus.host_we) begin
        ref_mem[bus.host_addr[9:2]] = merge_be(ref_word(bus.host_addr[9:2]), bus.host_wdata, bus.host_be);
        ref_wr[bus.host_addr[9:2]]  = 1'b1;
      end else begin
        sb.push_back('{owner: 1'b1, data: ref_word(bus.host_addr[9:2]), cyc: cycle});
      end
    end
  endtask

  task automatic sample();
    @(negedge clk);
    monitor();
  endtask

  task automatic next();
    @(posedge clk);
    #1;
    cycle++;
  endtask

  task automatic idle_inputs();
    bus.core_req = 1'b0; bus.core_we = 1'b0; bus.core_addr = 32'h0;
    bus.core_wdata = 32'h0; bus.core_be = 4'h0;
    bus.host_req = 1'b0; bus.host_we = 1'b0; bus.host_addr = 32'h0;
    bus.host_wdata = 32'h0; bus.host_be = 4'h0; bus.host_lock = 1'b0;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk1({tag, "_core_gnt"}, bus.core_gnt, 1'b0);
    chk1({tag, "_host_gnt"}, bus.host_gnt, 1'b0);
    chk1({tag, "_core_rvalid"}, bus.core_rvalid, 1'b0);
    chk1({tag, "_host_rvalid"}, bus.host_rvalid, 1'b0);
    chk1({tag, "_mem_en"}, bus.mem_en, 1'b0);
    chk1({tag, "_mem_we"}, bus.mem_we, 1'b0);
    chk1({tag, "_lock_ack"}, bus.host_lock_ack, 1'b0);
    chk32({tag, "_core_rdata"}, bus.core_rdata, 32'h0);
    chk32({tag, "_host_rdata"}, bus.host_rdata, 32'h0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    sb.delete();
    sample();
    chk_outputs_zero("rst");
    next();
    reset = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < LAT + 2; i++) begin
      sample();
      next();
    end
    chk32({tag, "_sb_empty"}, 32'(sb.size()), 32'h0);
  endtask

  initial begin
    int ack_cyc;
    bit seen;
    logic exp_c;

    // Round-robin table; the tie rows flip to the host under fixed priority
    vecs[0] = '{1'b1, 1'b0, 32'h100, 32'h200, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 32'h104, 32'h204, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 1'b1, 32'h108, 32'h208, !HP,  HP  };
    vecs[3] = '{1'b1, 1'b1, 32'h10C, 32'h20C, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 1'b0, 32'h110, 32'h210, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 32'h114, 32'h214, !HP,  HP  };
    vecs[6] = '{1'b0, 1'b1, 32'h118, 32'h218, 1'b0, 1'b1};
    vecs[7] = '{1'b1, 1'b0, 32'h11C, 32'h21C, 1'b1, 1'b0};

    reset = 1'b1;
    idle_inputs();
    sample();
    chk_outputs_zero("por");
    next();
    reset = 1'b0;

    // 1. Reset mid-read: the accepted read must never return
    bus.core_req = 1'b1; bus.core_addr = 32'h0;
    sample();
    chk1("t1_core_gnt", bus.core_gnt, 1'b1);
    next();
    reset = 1'b1;
    sb.delete();
    sample();
    chk_outputs_zero("t1_in_reset");
    next();
    reset = 1'b0;
    bus.core_req = 1'b0;
    drain("t1");

    // 2. Core-only stream of four reads
    do_reset();
    for (int i = 0; i < 4; i++) begin
      bus.core_req = 1'b1; bus.core_we = 1'b0; bus.core_addr = 32'(4 * i);
      sample();
      chk1("t2_core_gnt", bus.core_gnt, 1'b1);
      next();
    end
    bus.core_req = 1'b0;
    drain("t2");

    // Grant table
    do_reset();
    for (int i = 0; i < 8; i++) begin
      bus.core_req = vecs[i].c_req; bus.core_addr = vecs[i].c_addr;
      bus.host_req = vecs[i].h_req; bus.host_addr = vecs[i].h_addr;
      sample();
      chk1("tbl_core_gnt", bus.core_gnt, vecs[i].exp_cg);
      chk1("tbl_host_gnt", bus.host_gnt, vecs[i].exp_hg);
      chk32("tbl_mem_addr", bus.mem_addr,
            vecs[i].exp_cg ? vecs[i].c_addr : (vecs[i].exp_hg ? vecs[i].h_addr : 32'h0));
      next();
    end
    idle_inputs();
    drain("tbl");

    // 3. Continuous tie: alternating grants starting with the core
    do_reset();
    bus.core_req = 1'b1; bus.core_addr = 32'h10;
    bus.host_req = 1'b1; bus.host_addr = 32'h20;
    for (int i = 0; i < 8; i++) begin
      exp_c = HP ? 1'b0 : ((i % 2) == 0);
      sample();
      chk1("t3_core_gnt", bus.core_gnt, exp_c);
      chk1("t3_host_gnt", bus.host_gnt, !exp_c);
      next();
    end
    idle_inputs();
    drain("t3");

    // 4. Lock request while a core read is in flight
    do_reset();
    last_core_rv = -1;
    bus.core_req = 1'b1; bus.core_addr = 32'h8;
    sample();
    chk1("t4_core_gnt", bus.core_gnt, 1'b1);
    next();
    bus.core_req = 1'b0; bus.host_lock = 1'b1;
    sample();
    chk1("t4_ack_early", bus.host_lock_ack, 1'b0);
    next();
    bus.core_req = 1'b1; bus.core_addr = 32'hC;
    ack_cyc = -1;
    for (int i = 0; i < 8 && ack_cyc < 0; i++) begin
      sample();
      chk1("t4_core_stalled", bus.core_gnt, 1'b0);
      if (bus.host_lock_ack) ack_cyc = cycle;
      next();
    end
    chk1("t4_ack_seen", ack_cyc >= 0, 1'b1);
    chk1("t4_ack_after_rvalid", (last_core_rv >= 0) && (ack_cyc > last_core_rv), 1'b1);

    // 5. Locked host write then read-back, then release
    bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_addr = 32'h40;
    bus.host_wdata = 32'hDEAD_BEEF; bus.host_be = 4'b1111;
    sample();
    chk1("t5_wr_host_gnt", bus.host_gnt, 1'b1);
    chk1("t5_wr_core_gnt", bus.core_gnt, 1'b0);
    next();
    bus.host_we = 1'b0;
    sample();
    chk1("t5_rd_host_gnt", bus.host_gnt, 1'b1);
    next();
    bus.host_req = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      sample();
      if (bus.host_rvalid) begin
        seen = 1'b1;
        chk32("t5_host_rdata", bus.host_rdata, 32'hDEAD_BEEF);
      end
      next();
    end
    chk1("t5_host_rvalid_seen", seen, 1'b1);
    sample();
    chk32("t5_rdata_hold", bus.host_rdata, 32'hDEAD_BEEF);
    chk1("t5_ack_held", bus.host_lock_ack, 1'b1);
    next();
    bus.host_lock = 1'b0;
    sample();
    chk1("t5_drop_core_gnt", bus.core_gnt, 1'b0);
    next();
    sample();
    chk1("t5_unlock_core_gnt", bus.core_gnt, 1'b0);
    chk1("t5_unlock_ack", bus.host_lock_ack, 1'b0);
    next();
    sample();
    chk1("t5_resume_core_gnt", bus.core_gnt, 1'b1);
    next();
    idle_inputs();
    drain("t5");

`ifdef RV32I_MEM_ARB_HOST_PRIORITY_EN
    // 6. Fixed host priority under a continuous tie
    do_reset();
    bus.core_req = 1'b1; bus.core_addr = 32'h10;
    bus.host_req = 1'b1; bus.host_addr = 32'h20;
    for (int i = 0; i < 4; i++) begin
      sample();
      chk1("t6_host_gnt", bus.host_gnt, 1'b1);
      chk1("t6_core_gnt", bus.core_gnt, 1'b0);
      next();
    end
    bus.host_req = 1'b0;
    sample();
    chk1("t6_core_after", bus.core_gnt, 1'b1);
    next();
    idle_inputs();
    drain("t6");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
